// File: rtl/fre_measure_eq.sv
// Equal-precision frequency meter.
// The gate opens and closes on synchronised rising edges of signal_unknown, so
// the measurement always spans a whole number of input periods. The result is
// f = CLK_FREQ_HZ * n_cnt / m_cnt, produced by a bit-serial restoring divider.
module fre_measure_eq #(
  parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
  parameter int unsigned GATE_CYCLES    = 500_000,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned OUT_W          = 32
) (
  input  logic             std_clk,
  input  logic             std_reset,
  input  logic             signal_unknown,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] fre_val,
  output logic             err
);

  // Divider geometry: the numerator must hold CLK_FREQ_HZ * (2^CNT_W - 1).
  localparam int unsigned FREQ_W = $clog2(longint'(CLK_FREQ_HZ) + 1);
  localparam int unsigned NUM_W  = CNT_W + FREQ_W;
  localparam int unsigned STEP_W = $clog2(NUM_W + 1);

  // Longest gate plus timeout; m_cnt must be able to reach it without wrapping.
  localparam longint unsigned M_LIMIT_L = 64'(GATE_CYCLES) + 64'(TIMEOUT_CYCLES);

  localparam logic [CNT_W-1:0]  GATE_C    = CNT_W'(GATE_CYCLES);
  localparam logic [CNT_W-1:0]  M_LIMIT_C = CNT_W'(M_LIMIT_L);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_W-1:0]  CLK_K     = NUM_W'(CLK_FREQ_HZ);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_W - 1);

  // Elaboration-time parameter sanity checks.
  if (GATE_CYCLES < 1) begin : g_bad_gate
    $error("fre_measure_eq: GATE_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("fre_measure_eq: TIMEOUT_CYCLES must be at least 1");
  end
  if (CNT_W < 64 && M_LIMIT_L >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
    $error("fre_measure_eq: GATE_CYCLES+TIMEOUT_CYCLES must be below 2^CNT_W");
  end
  if (OUT_W >= NUM_W) begin : g_bad_out_w
    $error("fre_measure_eq: OUT_W must be narrower than the divider numerator");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEAS,
    ST_DIV,
    ST_DONE
  } state_e;

  // Input conditioning: two synchroniser flops, one history flop, one strobe.
  logic sync1_q, sync2_q, hist_q, rise_q;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   m_cnt_q, m_cnt_d;
  logic [CNT_W-1:0]   n_cnt_q, n_cnt_d;
  logic [CNT_W-1:0]   to_cnt_q, to_cnt_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [OUT_W-1:0]   fre_val_q, fre_val_d;
  logic               err_q, err_d;

  // Divider datapath helpers.
  logic [CNT_W-1:0]   m_inc, n_inc;
  logic [CNT_W:0]     rem_sh;
  logic               rem_ge;
  logic [NUM_W-1:0]   quot;

  // Synchronise signal_unknown and emit a one-cycle rising-edge strobe.
  always_ff @(posedge std_clk or negedge std_reset) begin
    if (!std_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value, which is what turns this chain into a real shift register.
      sync1_q <= signal_unknown;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      rise_q  <= sync2_q & ~hist_q;
    end
  end

  // State register plus counters, divider and result registers.
  always_ff @(posedge std_clk or negedge std_reset) begin
    if (!std_reset) begin
      state_q   <= ST_IDLE;
      m_cnt_q   <= '0;
      n_cnt_q   <= '0;
      to_cnt_q  <= '0;
      num_q     <= '0;
      rem_q     <= '0;
      step_q    <= '0;
      fre_val_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_cnt_q   <= m_cnt_d;
      n_cnt_q   <= n_cnt_d;
      to_cnt_q  <= to_cnt_d;
      num_q     <= num_d;
      rem_q     <= rem_d;
      step_q    <= step_d;
      fre_val_q <= fre_val_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic: arm, gate counting, serial divide and result load.
  always_comb begin
    // NOTE: every target gets a hold/default value first, so no path through
    // the case statement leaves a variable unassigned and no latch is inferred.
    state_d   = state_q;
    m_cnt_d   = m_cnt_q;
    n_cnt_d   = n_cnt_q;
    to_cnt_d  = to_cnt_q;
    num_d     = num_q;
    rem_d     = rem_q;
    step_d    = step_q;
    fre_val_d = fre_val_q;
    err_d     = err_q;

    m_inc  = m_cnt_q + 1'b1;
    n_inc  = n_cnt_q + 1'b1;
    // One restoring step: bring in the next numerator bit, try to subtract.
    rem_sh = {rem_q, num_q[NUM_W-1]};
    rem_ge = (rem_sh >= {1'b0, m_cnt_q});
    quot   = {num_q[NUM_W-2:0], rem_ge};

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_ARM;
          to_cnt_d = '0;
        end
      end

      ST_ARM: begin
        if (rise_q) begin
          // Gate opens on this strobe; counting starts next cycle.
          m_cnt_d = '0;
          n_cnt_d = '0;
          state_d = ST_MEAS;
        end else if (to_cnt_q == TO_LAST) begin
          state_d   = ST_DONE;
          fre_val_d = '0;
          err_d     = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      ST_MEAS: begin
        m_cnt_d = m_inc;
        if (rise_q) begin
          n_cnt_d = n_inc;
        end
        if (rise_q && (m_inc >= GATE_C)) begin
          // Gate closes: m_inc clocks span exactly n_inc input periods.
          state_d = ST_DIV;
          num_d   = CLK_K * {{FREQ_W{1'b0}}, n_inc};
          rem_d   = '0;
          step_d  = '0;
        end else if (m_inc == M_LIMIT_C) begin
          state_d   = ST_DONE;
          fre_val_d = '0;
          err_d     = 1'b1;
        end
      end

      ST_DIV: begin
        // The true difference is below m_cnt, so modulo-2^CNT_W is exact.
        rem_d  = rem_ge ? (rem_sh[CNT_W-1:0] - m_cnt_q) : rem_sh[CNT_W-1:0];
        num_d  = quot;
        step_d = step_q + 1'b1;
        if (step_q == STEP_LAST) begin
          state_d = ST_DONE;
          err_d   = 1'b0;
          if (|quot[NUM_W-1:OUT_W]) begin
            fre_val_d = '1;
          end else begin
            fre_val_d = quot[OUT_W-1:0];
          end
        end
      end

      ST_DONE: begin
        // Result registers were loaded on entry; this cycle only reports it.
        to_cnt_d = '0;
        state_d  = cont ? ST_ARM : ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign fre_val = fre_val_q;
  assign err     = err_q;

endmodule

// File: tb/tb_fre_measure_eq.sv
// Randomised scoreboard bench for fre_measure_eq.
// Stimulus pushes the expected {err, fre_val} for each measurement; a monitor
// pops and compares whenever the DUT pulses done. For a steady periodic input
// the reference is simply f = CLK_HZ / period (integer floor), since any gate
// of whole periods gives n*P clocks for n periods.
module tb_fre_measure_eq;

  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int unsigned GATE   = 1000;
  localparam int unsigned TMO    = 2000;

  logic        std_clk = 1'b0;
  logic        std_reset;
  logic        signal_unknown;
  logic        start;
  logic        cont;
  logic        busy;
  logic        done;
  logic [31:0] fre_val;
  logic        err;

  typedef struct {
    logic        err;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_pass   = 0;
  int   n_checks = 0;

  // Input generator controls.
  int gen_period = 0;
  int gen_high   = 0;
  int applied_p  = 0;

  fre_measure_eq #(
    .CLK_FREQ_HZ   (CLK_HZ),
    .GATE_CYCLES   (GATE),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (32),
    .OUT_W         (32)
  ) dut (
    .std_clk       (std_clk),
    .std_reset     (std_reset),
    .signal_unknown(signal_unknown),
    .start         (start),
    .cont          (cont),
    .busy          (busy),
    .done          (done),
    .fre_val       (fre_val),
    .err           (err)
  );

  always #5 std_clk = ~std_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model_steady(input int unsigned period);
    exp_t r;
    r.err = 1'b0;
    r.val = CLK_HZ / period;
    return r;
  endfunction

  function automatic exp_t model_timeout();
    exp_t r;
    r.err = 1'b1;
    r.val = 32'd0;
    return r;
  endfunction

  // Periodic input: rises 2 time units after a posedge, high for gen_high
  // cycles, low for the rest of gen_period. Period 0 holds the input low.
  initial begin
    int p;
    int h;
    signal_unknown = 1'b0;
    forever begin
      p = gen_period;
      h = gen_high;
      if (p == 0) begin
        signal_unknown = 1'b0;
        applied_p = 0;
        @(posedge std_clk);
      end else begin
        @(posedge std_clk);
        #2;
        signal_unknown = 1'b1;
        applied_p = p;
        repeat (h) @(posedge std_clk);
        #2;
        signal_unknown = 1'b0;
        repeat (p - h - 1) @(posedge std_clk);
      end
    end
  end

  // Scoreboard monitor: every done pulse consumes one expected result.
  always @(negedge std_clk) begin
    if (std_reset === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", done, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_err", err, mon_e.err);
        check("result_fre_val", fre_val, mon_e.val);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge std_clk);
  endtask

  // Change the input waveform and wait until a full new period is running.
  task automatic set_input(input int p, input int h);
    gen_period = p;
    gen_high   = h;
    for (int i = 0; i < 3000 && applied_p != p; i++) @(negedge std_clk);
    if (applied_p != p) begin
      $display("FAIL gen_settle: generator period %0d, wanted %0d", applied_p, p);
      $fatal(1);
    end
    tick(6);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("busy_rise", busy, 1);
  endtask

  task automatic wait_done(input int limit, output int cycles, output logic seen);
    cycles = 0;
    seen   = 1'b0;
    while (cycles < limit && !seen) begin
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        tick(1);
        cycles++;
      end
    end
  endtask

  // Single-shot measurement of a steady input.
  task automatic measure(input int p, input int h);
    exp_t e;
    int   c;
    logic seen;
    set_input(p, h);
    e = model_steady(p);
    exp_q.push_back(e);
    pulse_start();
    wait_done(8000, c, seen);
    check("done_seen", seen, 1);
    tick(1);
    check("busy_fall", busy, 0);
    tick(3);
    check("fre_val_hold", fre_val, e.val);
  endtask

  initial begin
    int   p;
    int   h;
    int   c;
    int   dones;
    int   busy_low;
    logic seen;

    std_reset = 1'b0;
    start     = 1'b0;
    cont      = 1'b0;
    tick(3);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_fre_val", fre_val, 0);
    check("reset_err", err, 0);
    std_reset = 1'b1;
    tick(2);

    // Directed and boundary periods: 1 MHz, non-multiple gate, max rate,
    // gate closing exactly at GATE with a single period.
    measure(50, 25);
    measure(7, 3);
    measure(4, 2);
    measure(1000, 500);

    // Random periods and duty cycles.
    for (int i = 0; i < 6; i++) begin
      p = int'($urandom_range(8, 900));
      h = int'($urandom_range(2, p - 2));
      measure(p, h);
    end

    // No edges at all: ARM times out TMO cycles after it is entered.
    set_input(0, 0);
    exp_q.push_back(model_timeout());
    pulse_start();
    wait_done(5000, c, seen);
    check("arm_timeout_seen", seen, 1);
    check("arm_timeout_latency", c, TMO);
    tick(1);
    check("arm_timeout_busy_fall", busy, 0);

    // Input stops after the gate has opened: MEAS times out.
    set_input(50, 25);
    exp_q.push_back(model_timeout());
    pulse_start();
    tick(300);
    gen_period = 0;
    wait_done(6000, c, seen);
    check("meas_timeout_seen", seen, 1);
    tick(1);
    check("meas_timeout_busy_fall", busy, 0);

    // Continuous mode: four results, busy held, then back to IDLE.
    set_input(50, 25);
    repeat (4) exp_q.push_back(model_steady(50));
    cont = 1'b1;
    pulse_start();
    dones    = 0;
    busy_low = 0;
    for (int i = 0; i < 12000 && dones < 3; i++) begin
      tick(1);
      if (busy !== 1'b1) busy_low++;
      if (done === 1'b1) dones++;
    end
    check("cont_done_count", dones, 3);
    check("cont_busy_held", busy_low, 0);
    tick(5);
    cont = 1'b0;
    wait_done(8000, c, seen);
    check("cont_last_done_seen", seen, 1);
    tick(1);
    check("cont_end_idle", busy, 0);
    check("cont_queue_drained", exp_q.size(), 0);

    // start re-asserted while measuring has no effect.
    exp_q.push_back(model_steady(50));
    pulse_start();
    tick(300);
    repeat (3) begin
      start = 1'b1;
      tick(2);
      start = 1'b0;
      tick(40);
    end
    wait_done(8000, c, seen);
    check("restart_done_seen", seen, 1);
    tick(20);
    check("restart_no_rearm", busy, 0);

    // Asynchronous reset in the middle of MEAS.
    pulse_start();
    tick(300);
    #1 std_reset = 1'b0;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_fre_val", fre_val, 0);
    tick(2);
    std_reset = 1'b1;
    tick(50);
    check("midreset_stays_idle", busy, 0);
    measure(20, 10);

    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
